beep_pattern_seq: RTL
=====================

Name: beep_pattern_seq

Overview:
- Upstream sequencer for the buzzer driver. Turns a one-cycle trigger plus a mode code into timed tone-enable and one-hot tone-select patterns.
- Outputs o_BeepEnable and o_divide feed the buzzer block's i_BeepEnable and i_divide inputs.
- Runs on the 32 kHz domain. An internal prescaler produces a base time tick, and all pattern durations are counted in ticks.

Parameters:
- TICK_DIV, 32: clocks per time tick (≈1 ms at 32.768 kHz). Legal range 1..256.
- T_SHORT, 50: ticks per short beep. Legal range 1..1023.
- T_GAP, 100: ticks of silence between beeps. Legal range 1..1023.
- T_LONG, 500: ticks per long beep. Legal range 1..1023.
- T_SIREN, 250: ticks per siren half-period. Legal range 1..1023.

Ports:
- i_clk_32k  in  1  sole clock
- i_Rst  in  1  reset; synchronous, active-high
- i_Trigger  in  1  start pattern; sampled only in IDLE
- i_Mode  in  2  pattern select; 0=KEY, 1=TRIPLE, 2=LONG, 3=SIREN
- i_Stop  in  1  abort current pattern
- o_BeepEnable  out  1  tone enable to buzzer block
- o_divide  out  5  one-hot tone select to buzzer block
- o_Busy  out  1  pattern in progress
- o_Done  out  1  one-cycle pulse on natural completion

Behaviour:
- Clock and reset:
  - Single clock i_clk_32k. Reset is synchronous and active-high on i_Rst.
  - With i_Rst high at an edge, all outputs are 0 after that edge and the FSM is in IDLE.
- All outputs are registered.
- States:
  - IDLE: o_BeepEnable=0, o_divide=0, o_Busy=0.
  - ON: o_BeepEnable=1, o_Busy=1, o_divide=current tone.
  - GAP: o_BeepEnable=0, o_Busy=1, o_divide holds the last tone.
- Start:
  - In IDLE with i_Trigger=1 and i_Stop=0 at edge N: latch i_Mode, enter ON.
  - The ON outputs are visible right after edge N (1-cycle latency).
  - i_Trigger and i_Mode are ignored outside IDLE.
- Phase timing:
  - On every phase entry, clear the prescaler (0..TICK_DIV-1) and the 10-bit tick counter.
  - A tick occurs when the prescaler reaches TICK_DIV-1.
  - A phase ends on the tick where tick count = duration-1, so phase length is exactly duration*TICK_DIV clocks.
- Tones:
  - KEY: 00001.
  - TRIPLE: 00010.
  - LONG: 00100.
  - SIREN: alternates 00001 and 00100, starting with 00001.
- Pattern sequences:
  - KEY: ON(T_SHORT), then IDLE.
  - LONG: ON(T_LONG), then IDLE.
  - TRIPLE: ON(T_SHORT), GAP(T_GAP), ON, GAP, ON, then IDLE. A 2-bit beep counter tracks progress; there is no trailing gap.
  - SIREN: ON(T_SIREN) repeated indefinitely, toggling the tone at each phase end. It never completes naturally.
- o_Done:
  - Pulses 1 for exactly one cycle, coincident with the first IDLE cycle after a natural completion (KEY, LONG, TRIPLE).
  - o_Busy falls in the same cycle.
- i_Stop:
  - In ON or GAP: next edge goes to IDLE. All outputs return to IDLE values, o_Done stays 0, and the counters clear.
  - Has priority over a phase end occurring in the same cycle.
  - In IDLE, i_Stop together with i_Trigger means the FSM stays in IDLE.
- A trigger in the same cycle that o_Done is high (FSM in IDLE) is accepted normally.
- The tick counter saturates logic-free: durations are bounded by the legal parameter range, so no wrap handling is required.

Test Plan:
- Parameters for all tests: TICK_DIV=4, T_SHORT=3, T_GAP=2, T_LONG=5, T_SIREN=2.
- KEY: trigger mode 0 at cycle 0 -> o_BeepEnable=1 and o_divide=00001 for cycles 1..12; at cycle 13 enable=0, divide=0, Busy=0, Done=1 for one cycle.
- TRIPLE: trigger mode 1 -> enable pattern 12 on / 8 off / 12 on / 8 off / 12 on with o_divide=00010 throughout Busy; Done pulses once, 53 cycles after trigger; o_Busy high for 52 cycles.
- SIREN + stop: trigger mode 3 -> o_divide alternates 00001/00100 every 8 cycles with enable steady 1; assert i_Stop at cycle 20 -> cycle 21 enable=0, divide=0, Busy=0, Done never asserted.
- Ignore while busy: start LONG, pulse i_Trigger with i_Mode=0 at cycle 5 -> pattern unchanged (20 cycles at 00100), single Done.
- Reset mid-pattern: i_Rst=1 during a TRIPLE gap -> all outputs 0 next cycle; new trigger after release starts cleanly with full-length first beep.
- Simultaneous events: i_Stop=1 and i_Trigger=1 together in IDLE -> remains IDLE. Retrigger in the Done cycle -> new pattern begins on the next cycle.

Source files
------------

// File: rtl/beep_pattern_seq.sv
// rtl/beep_pattern_seq.sv - timed beep/tone pattern sequencer feeding the buzzer driver
module beep_pattern_seq #(
  parameter int TICK_DIV = 32,
  parameter int T_SHORT  = 50,
  parameter int T_GAP    = 100,
  parameter int T_LONG   = 500,
  parameter int T_SIREN  = 250
) (
  input  logic       i_clk_32k,
  input  logic       i_Rst,
  input  logic       i_Trigger,
  input  logic [1:0] i_Mode,
  input  logic       i_Stop,
  output logic       o_BeepEnable,
  output logic [4:0] o_divide,
  output logic       o_Busy,
  output logic       o_Done
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  localparam logic [1:0] M_KEY    = 2'd0;
  localparam logic [1:0] M_TRIPLE = 2'd1;
  localparam logic [1:0] M_LONG   = 2'd2;
  localparam logic [1:0] M_SIREN  = 2'd3;

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [4:0] TONE_LO    = 5'b00001;
  localparam logic [4:0] TONE_MID   = 5'b00010;
  localparam logic [4:0] TONE_HI    = 5'b00100;

  state_t     r_state;
  logic [1:0] r_mode;
  logic [7:0] r_presc;
  logic [9:0] r_ticks;
  logic [1:0] r_beeps;
  logic [4:0] r_tone;

  state_t     w_state_nxt;
  logic [1:0] w_mode_nxt;
  logic [7:0] w_presc_nxt;
  logic [9:0] w_ticks_nxt;
  logic [1:0] w_beeps_nxt;
  logic [4:0] w_tone_nxt;
  logic       w_done_nxt;
  logic [9:0] w_dur;
  logic       w_tick;
  logic       w_phase_end;

  always_comb begin
    w_dur = 10'(T_SHORT);
    if (r_state == S_GAP) begin
      w_dur = 10'(T_GAP);
    end else begin
      case (r_mode)
        M_LONG:  w_dur = 10'(T_LONG);
        M_SIREN: w_dur = 10'(T_SIREN);
        default: w_dur = 10'(T_SHORT);
      endcase
    end
  end

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_phase_end = w_tick && (r_ticks == w_dur - 10'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
    w_ticks_nxt = w_tick ? r_ticks + 10'd1 : r_ticks;
    w_beeps_nxt = r_beeps;
    w_tone_nxt  = r_tone;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_presc_nxt = 8'd0;
        w_ticks_nxt = 10'd0;
        w_beeps_nxt = 2'd0;
        if (i_Trigger && !i_Stop) begin
          w_state_nxt = S_ON;
          w_mode_nxt  = i_Mode;
          case (i_Mode)
            M_TRIPLE: w_tone_nxt = TONE_MID;
            M_LONG:   w_tone_nxt = TONE_HI;
            default:  w_tone_nxt = TONE_LO;
          endcase
        end
      end
      default: begin
        if (i_Stop) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = 8'd0;
          w_ticks_nxt = 10'd0;
          w_beeps_nxt = 2'd0;
        end else if (w_phase_end) begin
          w_presc_nxt = 8'd0;
          w_ticks_nxt = 10'd0;
          if (r_state == S_GAP) begin
            w_state_nxt = S_ON;
            w_beeps_nxt = r_beeps + 2'd1;
          end else begin
            case (r_mode)
              M_SIREN: w_tone_nxt = (r_tone == TONE_LO) ? TONE_HI : TONE_LO;
              M_TRIPLE: begin
                // third beep has no trailing gap
                if (r_beeps == 2'd2) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
                  w_beeps_nxt = 2'd0;
                end else begin
                  w_state_nxt = S_GAP;
                end
              end
              default: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk_32k) begin
    if (i_Rst) begin
      r_state      <= S_IDLE;
      r_mode       <= M_KEY;
      r_presc      <= 8'd0;
      r_ticks      <= 10'd0;
      r_beeps      <= 2'd0;
      r_tone       <= 5'd0;
      o_BeepEnable <= 1'b0;
      o_divide     <= 5'd0;
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_presc      <= w_presc_nxt;
      r_ticks      <= w_ticks_nxt;
      r_beeps      <= w_beeps_nxt;
      r_tone       <= w_tone_nxt;
      o_BeepEnable <= (w_state_nxt == S_ON);
      o_divide     <= (w_state_nxt == S_IDLE) ? 5'd0 : w_tone_nxt;
      o_Busy       <= (w_state_nxt != S_IDLE);
      o_Done       <= w_done_nxt;
    end
  end

endmodule
